// File: rtl/cpu_pkg.sv
// Shared CPU package: operation and state encodings used by the control
// unit and the iterative multiply sequencer.
//   mul_op_t    : 2-bit M-extension multiply op as decoded from funct3
//   mul_state_t : sequencer state encoding
package cpu_pkg;

  typedef enum logic [1:0] {
    MUL      = 2'b00,  // low half of product
    MULH     = 2'b01,  // signed x signed, high half
    MULHU    = 2'b10,  // unsigned x unsigned, high half
    MUL_RSVD = 2'b11   // reserved, executes as MUL
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } mul_state_t;

endpackage

// File: rtl/mul_seq.sv
// Iterative shift-add multiplier for mul / mulh / mulhu.
// One product bit is retired per RUN cycle; a FIX cycle applies the sign
// correction and selects the product half, then DONE pulses for writeback.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start, op, a, b  request and operands, sampled in IDLE
//   flush          abort an in-flight operation
//   stall          combinational pipeline freeze
//   busy           high in RUN and FIX
//   done           registered one-cycle completion pulse
//   result         registered product half, held until the next completion
module mul_seq
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;

  mul_state_t         state, next_state;
  mul_op_t            op_q;
  logic [WIDTH-1:0]   mcand, mplier;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [CW-1:0]      cnt;
  logic               neg;

  logic               accept, last_iter, fix_ok;
  logic [WIDTH-1:0]   a_mag, b_mag, addend;
  logic [WIDTH:0]     sum;

  assign accept    = (state == IDLE) & start & ~flush;
  assign last_iter = (cnt == CW'(WIDTH - 1));
  assign fix_ok    = (state == FIX) & ~flush;

  // Operand magnitudes, partial-sum adder and final sign correction.
  // 2^(WIDTH-1) negated is itself, which is the correct unsigned magnitude.
  always_comb begin
    a_mag    = a;
    b_mag    = b;
    addend   = {WIDTH{1'b0}};
    prod_fix = prod;
    if (mul_op_t'(op) == MULH) begin
      a_mag = a[WIDTH-1] ? (~a + {{(WIDTH-1){1'b0}}, 1'b1}) : a;
      b_mag = b[WIDTH-1] ? (~b + {{(WIDTH-1){1'b0}}, 1'b1}) : b;
    end else begin
      a_mag = a;
      b_mag = b;
    end
    if (mplier[0]) begin
      addend = mcand;
    end else begin
      addend = {WIDTH{1'b0}};
    end
    if (neg) begin
      prod_fix = ~prod + {{(2*WIDTH-1){1'b0}}, 1'b1};
    end else begin
      prod_fix = prod;
    end
  end

  // Carry-out of the upper-half add becomes the new product MSB on shift.
  assign sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, addend};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; flush in RUN or FIX abandons the operation.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) next_state = RUN;
        else        next_state = IDLE;
      end
      RUN: begin
        if (flush)          next_state = IDLE;
        else if (last_iter) next_state = FIX;
        else                next_state = RUN;
      end
      FIX: begin
        if (flush) next_state = IDLE;
        else       next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Status outputs; stall covers the request cycle so the core freezes at once.
  always_comb begin
    stall = 1'b0;
    busy  = 1'b0;
    case (state)
      IDLE: begin
        stall = accept;
        busy  = 1'b0;
      end
      RUN, FIX: begin
        stall = 1'b1;
        busy  = 1'b1;
      end
      DONE: begin
        stall = 1'b0;
        busy  = 1'b0;
      end
      default: begin
        stall = 1'b0;
        busy  = 1'b0;
      end
    endcase
  end

  // Datapath: operand capture, shift-add iterations, sign fix-up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= MUL;
      mcand  <= {WIDTH{1'b0}};
      mplier <= {WIDTH{1'b0}};
      prod   <= {(2*WIDTH){1'b0}};
      cnt    <= {CW{1'b0}};
      neg    <= 1'b0;
    end else if (accept) begin
      op_q   <= mul_op_t'(op);
      mcand  <= a_mag;
      mplier <= b_mag;
      prod   <= {(2*WIDTH){1'b0}};
      cnt    <= {CW{1'b0}};
      neg    <= (mul_op_t'(op) == MULH) ? (a[WIDTH-1] ^ b[WIDTH-1]) : 1'b0;
    end else if ((state == RUN) && !flush) begin
      prod   <= {sum, prod[WIDTH-1:1]};
      mplier <= {1'b0, mplier[WIDTH-1:1]};
      cnt    <= cnt + CW'(1);
    end else if (fix_ok) begin
      prod   <= prod_fix;
    end
  end

  // Registered completion pulse and result; a flushed FIX leaves result alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done   <= 1'b0;
      result <= {WIDTH{1'b0}};
    end else begin
      done <= fix_ok;
      if (fix_ok) begin
        if ((op_q == MULH) || (op_q == MULHU)) result <= prod_fix[2*WIDTH-1:WIDTH];
        else                                   result <= prod_fix[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Directed self-checking bench for mul_seq (WIDTH=32).
module tb_mul_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_assert;
  int n_fail;

  mul_seq #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from IDLE and check latency, stall length, result, pulse width.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input string tag);
    int cyc;
    int stl;
    start = 1'b1; op = o; a = x; b = y;
    #1;
    check({tag, " stall_req"}, 32'(stall), 32'd1);
    tick();
    start = 1'b0;
    cyc = 1;
    stl = 0;
    while (done !== 1'b1 && cyc < 100) begin
      if (stall === 1'b1) stl++;
      tick();
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'd34);
    check({tag, " stall_cycles"}, 32'(stl), 32'd33);
    check({tag, " result"}, result, exp);
    check({tag, " stall_done"}, 32'(stall), 32'd0);
    tick();
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " result_hold"}, result, exp);
  endtask

  initial begin
    int cyc;
    int seen_done;
    n_assert = 0;
    n_fail   = 0;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0; flush = 1'b0;

    // Reset state
    #3;
    check("rst stall", 32'(stall), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst result", result, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Main function
    run_op(2'b00, 32'd7,        32'd6,        32'h0000002A, "mul 7x6");
    run_op(2'b01, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, "mulh -1x2");
    run_op(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, "mulh minxmin");
    run_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu max");
    run_op(2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, "mul lo -1x2");
    run_op(2'b10, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, "mulhu hi");
    run_op(2'b01, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, "mulh -1xmin");
    run_op(2'b11, 32'd3,        32'd5,        32'h0000000F, "rsvd as mul");

    // Flush at RUN cycle 10: back to IDLE, no done, result untouched
    start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("flush pre busy", 32'(busy), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush busy", 32'(busy), 32'd0);
    check("flush stall", 32'(stall), 32'd0);
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) seen_done = 1;
      tick();
    end
    check("flush no done", 32'(seen_done), 32'd0);
    check("flush result", result, 32'h0000000F);

    // start together with flush in IDLE is not accepted
    start = 1'b1; flush = 1'b1; a = 32'd9; b = 32'd9;
    #1;
    check("start+flush stall", 32'(stall), 32'd0);
    tick();
    start = 1'b0; flush = 1'b0;
    check("start+flush busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-RUN
    start = 1'b1; op = 2'b00; a = 32'd4; b = 32'd4;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("midrun busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst busy", 32'(busy), 32'd0);
    check("arst stall", 32'(stall), 32'd0);
    check("arst done", 32'(done), 32'd0);
    check("arst result", result, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("arst idle busy", 32'(busy), 32'd0);

    // Back-to-back: start held high; operands changed while busy
    start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd3;
    tick();
    a = 32'd10; b = 32'd10;
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("b2b first latency", 32'(cyc), 32'd34);
    check("b2b first result", result, 32'd6);
    tick();
    check("b2b idle busy", 32'(busy), 32'd0);
    check("b2b idle stall", 32'(stall), 32'd1);
    tick();
    start = 1'b0;
    cyc = 2;
    while (done !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("b2b second spacing", 32'(cyc), 32'd35);
    check("b2b second result", result, 32'd100);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
